// File: rtl/apb_if_pkg.sv
// Shared APB types: requester FSM states and the pprot attribute layout.
package apb_if_pkg;

    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    // Packed MSB-first, so pprot[0]=privileged, [1]=nonsecure, [2]=instruction.
    typedef struct packed {
        logic instruction;
        logic nonsecure;
        logic privileged;
    } apb_prot_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; expired flags the TIMEOUT-th consecutive pready-low cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] count_q;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count_q <= '0;
                end else if (enable) begin
                    count_q <= count_q + 1'b1;
                end
            end

            // count_q holds the low cycles already seen, so LAST means this is the final one.
            assign expired = enable && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding command becomes a SETUP/ACCESS transfer and a held response.
module apb_requester
    import apb_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [APB_PROT_W-1:0]   cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [APB_PROT_W-1:0]   pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Handshakes: a beat transfers on the edge where valid && ready; the offering side keeps
    // valid and its payload stable until then, and ready never waits on valid.
    apb_req_state_e state_q, state_d;
    apb_prot_t      prot_q;
    logic           accept;
    logic           expired;
    logic           access_done;

    assign accept      = cmd_valid && cmd_ready;
    assign access_done = (state_q == ACCESS) && (pready || expired);

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ACCESS),
        .enable ((state_q == ACCESS) && !pready),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = SETUP;
            SETUP:                    state_d = ACCESS;
            ACCESS:  if (access_done) state_d = RESP;
            RESP:    if (rsp_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready   <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            prot_q      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE);
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : STRB_W'(0);
                prot_q <= apb_prot_t'(cmd_prot);
            end
            // Completion takes priority over an expiry landing on the same cycle.
            if (state_q == ACCESS && pready) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (state_q == ACCESS && expired) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign pprot     = prot_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a cycle-stepped completer and hand-computed expectations.
module tb_apb_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int tests_run = 0;
    int tests_failed = 0;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    // One full transfer. waits = pready-low ACCESS cycles before pready rises (>=TO means stuck).
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic slverr, input logic [DW-1:0] rdata, input int rsp_delay);
        int            k;
        logic          exp_to;
        logic [3:0]    exp_strb;
        logic [DW-1:0] exp_rdata;
        int            exp_cycles;
        exp_to     = (waits >= TO);
        exp_cycles = exp_to ? TO : waits + 1;
        exp_strb   = wr ? strb : 4'h0;
        exp_rdata  = (wr || exp_to) ? '0 : rdata;

        wait_cmd_ready();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_strb = strb; cmd_prot = prot;
        pready = 1'b0; pslverr = 1'b0; prdata = rdata;
        step();
        cmd_valid = 1'b0;
        check_eq("setup_psel", 64'(psel), 64'd1);
        check_eq("setup_penable", 64'(penable), 64'd0);
        check_eq("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("setup_paddr", 64'(paddr), 64'(addr));
        check_eq("setup_pwrite", 64'(pwrite), 64'(wr));
        check_eq("setup_pstrb", 64'(pstrb), 64'(exp_strb));
        check_eq("setup_pprot", 64'(pprot), 64'(prot));
        if (wr) check_eq("setup_pwdata", 64'(pwdata), 64'(wdata));
        step();
        k = 1;
        while (psel && penable && k <= 60) begin
            check_eq("access_paddr", 64'(paddr), 64'(addr));
            check_eq("access_rsp_valid", 64'(rsp_valid), 64'd0);
            pready  = (k > waits);
            pslverr = slverr && pready;
            step();
            k++;
        end
        // Values offered outside ACCESS must be ignored.
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0BAD0;
        check_eq("access_cycles", 64'(k - 1), 64'(exp_cycles));
        check_eq("resp_psel", 64'(psel), 64'd0);
        check_eq("resp_valid", 64'(rsp_valid), 64'd1);
        check_eq("resp_err", 64'(rsp_err), 64'(exp_to || slverr));
        check_eq("resp_timeout", 64'(rsp_timeout), 64'(exp_to));
        check_eq("resp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        for (int i = 0; i < rsp_delay; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1; cmd_addr = addr ^ 32'h100;
            step();
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check_eq("hold_err", 64'(rsp_err), 64'(exp_to || slverr));
            check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check_eq("hold_psel", 64'(psel), 64'd0);
            check_eq("hold_paddr", 64'(paddr), 64'(addr));
        end
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_eq("done_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("done_psel", 64'(psel), 64'd0);
        check_eq("done_cmd_ready", 64'(cmd_ready), 64'd1);
        pready = 1'b0; pslverr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b0;
        pslverr = 1'b0;
        repeat (3) step();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_psel", 64'(psel), 64'd0);
        check_eq("rst_penable", 64'(penable), 64'd0);
        check_eq("rst_pwrite", 64'(pwrite), 64'd0);
        check_eq("rst_paddr", 64'(paddr), 64'd0);
        check_eq("rst_pwdata", 64'(pwdata), 64'd0);
        check_eq("rst_pstrb", 64'(pstrb), 64'd0);
        check_eq("rst_pprot", 64'(pprot), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        step();
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // zero-wait write, read with 3 waits, write with pslverr
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        do_xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'b101, 3, 1'b0, 32'h12345678, 0);
        do_xfer(1'b1, 32'h30, 32'hA5A5_0F0F, 4'h3, 3'b010, 1, 1'b1, 32'h0, 0);
        // stuck completer times out; pready in the final counted cycle completes normally
        do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b001, 100, 1'b0, 32'hCAFEF00D, 0);
        do_xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'b001, TO - 1, 1'b0, 32'hCAFEF00D, 0);
        // back-pressured response with a new command waiting
        do_xfer(1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 2, 1'b1, 32'h0BADCAFE, 5);

        // reset in the middle of ACCESS
        wait_cmd_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h11;
        cmd_strb = 4'h1; cmd_prot = 3'b111; pready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_eq("mid_penable", 64'(penable), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_psel", 64'(psel), 64'd0);
        check_eq("mid_rst_penable", 64'(penable), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_paddr", 64'(paddr), 64'd0);
        check_eq("mid_rst_pwrite", 64'(pwrite), 64'd0);
        check_eq("mid_rst_pprot", 64'(pprot), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            check_eq("post_rst_no_psel", 64'(psel), 64'd0);
        end
        do_xfer(1'b0, 32'h70, 32'h0, 4'h0, 3'b100, 0, 1'b0, 32'h87654321, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (manager) that turns a single-outstanding command/response handshake into APB4 SETUP/ACCESS transfers. It is the initiating end of the library's APB interface and drives completer-side blocks and verification models. It supports wait states, PSLVERR, and a wait-state timeout, so a hung completer can never stall the initiator.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/paddr
- DATA_WIDTH, 32, data width; must be 8, 16 or 32
- TIMEOUT, 256, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  requester idle, command accepted when both are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write strobes; forced to 0 on reads
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1  APB controls
- paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH; pstrb  out  DATA_WIDTH/8; pprot  out  3
- prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, register cmd fields into the APB outputs and go to SETUP.
- SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
- ACCESS: psel=1, penable=1. The wait counter increments each cycle pready=0.
  - pready=1: capture prdata (reads only) and pslverr, then go to RESP.
  - Counter reaches TIMEOUT with pready still low: abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP: psel=penable=0, rsp_valid=1, and the response is held stable until rsp_ready. On rsp_ready go to IDLE.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the end of ACCESS. They hold their last value in IDLE/RESP; they are never driven X.
- pready and pslverr are sampled only in ACCESS. Values in other states are ignored.
- A new command is not accepted in RESP. Exactly one transfer is outstanding at a time.

## Timing
- Reset: state=IDLE, cmd_ready=1 (registered low during rst), psel=penable=pwrite=0, paddr/pwdata/pstrb/pprot=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, counter=0.
- Zero-wait transfer, with acceptance at edge N: SETUP at cycle N+1, ACCESS at N+2 (pready=1), rsp_valid at N+3. With rsp_ready already high, cmd_ready is back at N+4. Minimum period is 4 cycles per transfer.
- Each wait state adds one cycle of ACCESS.
- Timeout: with TIMEOUT=T, the abort occurs after exactly T ACCESS cycles with pready low, and rsp_valid rises on the next cycle. If pready=1 arrives in the same cycle as the final count, completion wins (no timeout).
- rst asserted mid-transfer: psel/penable drop the next edge and no response is produced. The completer is responsible for tolerating the abandoned transfer.

## Structure
- The shared package apb_if_pkg holds:
  - apb_req_state_e (IDLE/SETUP/ACCESS/RESP)
  - apb_prot_t (3-bit: privileged, nonsecure, instruction)
  - localparam APB_PROT_W=3
- Sub-module apb_wait_timer: counter with clear, enable and expired outputs, parameterised by TIMEOUT, tied off when TIMEOUT=0.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready always 1 -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read addr 0x20, pready low for 3 ACCESS cycles, prdata=0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata=0x12345678; paddr stable throughout.
- Write with pslverr=1 when pready=1 -> rsp_err=1, rsp_timeout=0.
- TIMEOUT=8, pready stuck 0 -> exactly 8 ACCESS cycles, then rsp_err=1 and rsp_timeout=1. Repeat with pready=1 in the 8th cycle -> normal completion.
- rsp_ready held low 5 cycles in RESP, with cmd_valid high -> response stable, cmd_ready=0, no new psel until 1 cycle after rsp_ready.
- rst pulsed in ACCESS -> all outputs at reset values the next cycle, rsp_valid never rises, and the next command completes normally.
